fft_bfly_stage_p: RTL and testbench

//  Parametrised, pipelined radix-2 DIT butterfly stage: P lanes, each y0=a+b*w, y1=a-b*w.

---
 rtl/fft_bfly_stage_p.sv | 168 ++++++++++++++++
 tb/tb_fft_bfly_stage_p.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bfly_stage_p.sv
// Pipelined radix-2 DIT butterfly stage: P lanes of y0=a+b*w, y1=a-b*w with
// valid/ready flow control, per-frame /2 scaling, saturation and sticky overflow.

module fft_bfly_lane #(
  parameter int W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                adv_i,
  input  logic                scale_i,
  input  logic signed [W-1:0] a_re_i,
  input  logic signed [W-1:0] a_im_i,
  input  logic signed [W-1:0] b_re_i,
  input  logic signed [W-1:0] b_im_i,
  input  logic signed [W-1:0] w_re_i,
  input  logic signed [W-1:0] w_im_i,
  output logic [W-1:0]        y0_re_o,
  output logic [W-1:0]        y0_im_o,
  output logic [W-1:0]        y1_re_o,
  output logic [W-1:0]        y1_im_o,
  output logic                sat_o
);
  localparam logic signed [2*W:0] RND  = {{(W+3){1'b0}}, 1'b1, {(W-3){1'b0}}};
  localparam logic signed [W+3:0] ONE  = {{(W+3){1'b0}}, 1'b1};
  localparam logic signed [W+3:0] SMAX = {5'b00000, {(W-1){1'b1}}};
  localparam logic signed [W+3:0] SMIN = {5'b11111, {(W-1){1'b0}}};

  logic signed [2*W:0] br, bi, wr, wi, x_re, x_im;
  logic signed [W+2:0] p_re_d, p_im_d, p_re_q, p_im_q;
  logic signed [W-1:0] a_re_q, a_im_q;
  logic [W:0]          f0r, f0i, f1r, f1i;
  logic [W-1:0]        y0_re_q, y0_im_q, y1_re_q, y1_im_q;

  // Optional round-half-up halving, then clamp; MSB of the result flags a clamp.
  function automatic logic [W:0] fin(input logic signed [W+3:0] s, input logic scl);
    logic signed [W+3:0] t;
    t = scl ? ((s + ONE) >>> 1) : s;
    if (t > SMAX)      return {1'b1, SMAX[W-1:0]};
    else if (t < SMIN) return {1'b1, SMIN[W-1:0]};
    else               return {1'b0, t[W-1:0]};
  endfunction

  always_comb begin
    br     = (2*W+1)'(b_re_i);
    bi     = (2*W+1)'(b_im_i);
    wr     = (2*W+1)'(w_re_i);
    wi     = (2*W+1)'(w_im_i);
    x_re   = br * wr - bi * wi;
    x_im   = br * wi + bi * wr;
    p_re_d = (W+3)'((x_re + RND) >>> (W-2));
    p_im_d = (W+3)'((x_im + RND) >>> (W-2));
    f0r    = fin((W+4)'(a_re_q) + (W+4)'(p_re_q), scale_i);
    f0i    = fin((W+4)'(a_im_q) + (W+4)'(p_im_q), scale_i);
    f1r    = fin((W+4)'(a_re_q) - (W+4)'(p_re_q), scale_i);
    f1i    = fin((W+4)'(a_im_q) - (W+4)'(p_im_q), scale_i);
    sat_o  = f0r[W] | f0i[W] | f1r[W] | f1i[W];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_re_q  <= '0;
      a_im_q  <= '0;
      p_re_q  <= '0;
      p_im_q  <= '0;
      y0_re_q <= '0;
      y0_im_q <= '0;
      y1_re_q <= '0;
      y1_im_q <= '0;
    end else if (adv_i) begin
      a_re_q  <= a_re_i;
      a_im_q  <= a_im_i;
      p_re_q  <= p_re_d;
      p_im_q  <= p_im_d;
      y0_re_q <= f0r[W-1:0];
      y0_im_q <= f0i[W-1:0];
      y1_re_q <= f1r[W-1:0];
      y1_im_q <= f1i[W-1:0];
    end
  end

  assign y0_re_o = y0_re_q;
  assign y0_im_o = y0_im_q;
  assign y1_re_o = y1_re_q;
  assign y1_im_o = y1_im_q;
endmodule

module fft_bfly_stage_p #(
  parameter int W = 16,
  parameter int P = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic           in_sop_i,
  input  logic           in_scale_i,
  input  logic [P*W-1:0] in_a_re_i,
  input  logic [P*W-1:0] in_a_im_i,
  input  logic [P*W-1:0] in_b_re_i,
  input  logic [P*W-1:0] in_b_im_i,
  input  logic [P*W-1:0] in_w_re_i,
  input  logic [P*W-1:0] in_w_im_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic           out_sop_o,
  output logic [P*W-1:0] out_y0_re_o,
  output logic [P*W-1:0] out_y0_im_o,
  output logic [P*W-1:0] out_y1_re_o,
  output logic [P*W-1:0] out_y1_im_o,
  output logic           ovf_o,
  input  logic           ovf_clr_i
);
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_q;
  logic            adv, beat_sc, scale_q, sc1_q, sop1_q, sop2_q, ovf_q;
  logic [P-1:0]    lane_sat;

  // Whole pipeline stalls only when the output register holds an unconsumed beat.
  assign adv        = ~vld_pipe_q[STAGES] | out_ready_i;
  assign in_ready_o = adv;
  assign beat_sc    = in_sop_i ? in_scale_i : scale_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      sop1_q     <= 1'b0;
      sop2_q     <= 1'b0;
      sc1_q      <= 1'b0;
      scale_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (adv) begin
        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid_i};
        sop1_q     <= in_valid_i & in_sop_i;
        sop2_q     <= sop1_q;
        sc1_q      <= beat_sc;
        if (in_valid_i && in_sop_i) scale_q <= in_scale_i;
      end
      if (adv && vld_pipe_q[1] && (|lane_sat)) ovf_q <= 1'b1;
      else if (ovf_clr_i)                      ovf_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_lane
    fft_bfly_lane #(.W(W)) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .adv_i   (adv),
      .scale_i (sc1_q),
      .a_re_i  (in_a_re_i[k*W +: W]),
      .a_im_i  (in_a_im_i[k*W +: W]),
      .b_re_i  (in_b_re_i[k*W +: W]),
      .b_im_i  (in_b_im_i[k*W +: W]),
      .w_re_i  (in_w_re_i[k*W +: W]),
      .w_im_i  (in_w_im_i[k*W +: W]),
      .y0_re_o (out_y0_re_o[k*W +: W]),
      .y0_im_o (out_y0_im_o[k*W +: W]),
      .y1_re_o (out_y1_re_o[k*W +: W]),
      .y1_im_o (out_y1_im_o[k*W +: W]),
      .sat_o   (lane_sat[k])
    );
  end

  assign out_valid_o = vld_pipe_q[STAGES];
  assign out_sop_o   = sop2_q;
  assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_fft_bfly_stage_p.sv
// Bench for fft_bfly_stage_p (W=16, P=2): directed butterfly cases plus a
// randomized stream scored against an integer reference model.

module tb_fft_bfly_stage_p;
  localparam int W = 16;
  localparam int P = 2;
  localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W-1));

  logic clk = 1'b0, rst_n = 1'b1;
  logic in_valid = 1'b0, in_sop = 1'b0, in_scale = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic in_ready, out_valid, out_sop, ovf;
  logic [P*W-1:0] in_a_re = '0, in_a_im = '0, in_b_re = '0, in_b_im = '0, in_w_re = '0, in_w_im = '0;
  logic [P*W-1:0] out_y0_re, out_y0_im, out_y1_re, out_y1_im;

  typedef struct packed {
    logic [P*W-1:0] y0r, y0i, y1r, y1i;
    logic sop;
    logic sat;
  } beat_t;

  beat_t expq[$];
  int    ncmp = 0, nfail = 0;
  logic  tb_scale = 1'b0, exp_ovf = 1'b0;

  always #5 clk = ~clk;

  fft_bfly_stage_p #(.W(W), .P(P)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_sop_i(in_sop), .in_scale_i(in_scale),
    .in_a_re_i(in_a_re), .in_a_im_i(in_a_im), .in_b_re_i(in_b_re), .in_b_im_i(in_b_im),
    .in_w_re_i(in_w_re), .in_w_im_i(in_w_im),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sop_o(out_sop),
    .out_y0_re_o(out_y0_re), .out_y0_im_o(out_y0_im), .out_y1_re_o(out_y1_re), .out_y1_im_o(out_y1_im),
    .ovf_o(ovf), .ovf_clr_i(ovf_clr)
  );

  // Reference: exact integer arithmetic on the complex values.
  function automatic logic [W:0] fin(input longint s, input logic sc);
    longint t;
    t = sc ? ((s + 1) >>> 1) : s;
    if (t > MAXV) return {1'b1, W'(MAXV)};
    if (t < MINV) return {1'b1, W'(MINV)};
    return {1'b0, t[W-1:0]};
  endfunction

  function automatic beat_t model(input logic sop, input logic sc);
    beat_t r;
    logic [W:0] f;
    longint ar, ai, br, bi, wr, wi, pr, pi, half;
    r = '0;
    r.sop = sop;
    half = longint'(1) <<< (W-3);
    for (int k = 0; k < P; k++) begin
      ar = longint'($signed(in_a_re[k*W +: W]));
      ai = longint'($signed(in_a_im[k*W +: W]));
      br = longint'($signed(in_b_re[k*W +: W]));
      bi = longint'($signed(in_b_im[k*W +: W]));
      wr = longint'($signed(in_w_re[k*W +: W]));
      wi = longint'($signed(in_w_im[k*W +: W]));
      pr = (br * wr - bi * wi + half) >>> (W-2);
      pi = (br * wi + bi * wr + half) >>> (W-2);
      f = fin(ar + pr, sc); r.y0r[k*W +: W] = f[W-1:0]; r.sat |= f[W];
      f = fin(ai + pi, sc); r.y0i[k*W +: W] = f[W-1:0]; r.sat |= f[W];
      f = fin(ar - pr, sc); r.y1r[k*W +: W] = f[W-1:0]; r.sat |= f[W];
      f = fin(ai - pi, sc); r.y1i[k*W +: W] = f[W-1:0]; r.sat |= f[W];
    end
    return r;
  endfunction

  function automatic logic [4*P*W:0] dat(input beat_t b);
    return b[4*P*W:0+1];
  endfunction

  task automatic rand_data();
    for (int k = 0; k < P; k++) begin
      in_a_re[k*W +: W] = W'($urandom()); in_a_im[k*W +: W] = W'($urandom());
      in_b_re[k*W +: W] = W'($urandom()); in_b_im[k*W +: W] = W'($urandom());
      in_w_re[k*W +: W] = W'($urandom()); in_w_im[k*W +: W] = W'($urandom());
    end
  endtask

  task automatic zero_data();
    in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0; in_w_re = '0; in_w_im = '0;
  endtask

  // Called at a negedge: samples the handshake, records accepted beats, moves to next negedge.
  task automatic tick(output logic cons, output logic ov, output logic ir, output beat_t got);
    logic sc;
    #1;
    ov   = out_valid;
    ir   = in_ready;
    cons = out_valid & out_ready;
    got  = {out_y0_re, out_y0_im, out_y1_re, out_y1_im, out_sop, ovf};
    if (in_valid && in_ready) begin
      sc = in_sop ? in_scale : tb_scale;
      if (in_sop) tb_scale = in_scale;
      expq.push_back(model(in_sop, sc));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic c, ov, ir;
    beat_t g;
    in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick(c, ov, ir, g);
    expq.delete();
  endtask

  task automatic test_reset();
    ncmp++;
    if ({out_valid, out_sop, ovf} !== 3'b000 || {out_y0_re, out_y0_im, out_y1_re, out_y1_im} !== '0) begin
      nfail++;
      $display("FAIL reset_state: valid/sop/ovf %b%b%b y0re %h want 000 and zero outputs", out_valid, out_sop, ovf, out_y0_re);
    end
    ncmp++;
    if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_identity();
    logic c, ov, ir;
    beat_t g, e;
    rand_data();
    in_a_re[W-1:0] = 16'd1000; in_a_im[W-1:0] = '0; in_b_re[W-1:0] = 16'd500; in_b_im[W-1:0] = '0;
    in_w_re[W-1:0] = 16'd16384; in_w_im[W-1:0] = '0;
    in_valid = 1'b1; in_sop = 1'b1; in_scale = 1'b0; out_ready = 1'b1;
    tick(c, ov, ir, g);
    in_valid = 1'b0; in_sop = 1'b0;
    tick(c, ov, ir, g);
    ncmp++;
    if (ov !== 1'b0) begin nfail++; $display("FAIL identity_lat1: out_valid %b want 0", ov); end
    tick(c, ov, ir, g);
    ncmp++;
    if (c !== 1'b1) begin nfail++; $display("FAIL identity_lat2: out_valid %b want 1", c); end
    else begin
      e = expq.pop_front(); exp_ovf |= e.sat;
      ncmp++;
      if (dat(g) !== dat(e)) begin nfail++; $display("FAIL identity_model: got %h want %h", dat(g), dat(e)); end
      ncmp++;
      if ({g.y0r[W-1:0], g.y0i[W-1:0], g.y1r[W-1:0], g.y1i[W-1:0], g.sop} !== {16'd1500, 16'd0, 16'd500, 16'd0, 1'b1}) begin
        nfail++; $display("FAIL identity_lane0: got %h %h %h %h sop %b want 05dc 0000 01f4 0000 sop 1",
                          g.y0r[W-1:0], g.y0i[W-1:0], g.y1r[W-1:0], g.y1i[W-1:0], g.sop);
      end
    end
    idle(2);
  endtask

  task automatic test_twiddle();
    logic c, ov, ir;
    beat_t g, e;
    rand_data();
    in_a_re[W-1:0] = 16'd1000; in_a_im[W-1:0] = '0; in_b_re[W-1:0] = 16'd500; in_b_im[W-1:0] = '0;
    in_w_re[W-1:0] = '0; in_w_im[W-1:0] = -16'sd16384;
    in_valid = 1'b1; in_sop = 1'b1; in_scale = 1'b0; out_ready = 1'b1;
    tick(c, ov, ir, g);
    in_valid = 1'b0; in_sop = 1'b0;
    tick(c, ov, ir, g);
    tick(c, ov, ir, g);
    ncmp++;
    if (c !== 1'b1) begin nfail++; $display("FAIL twiddle_valid: got %b want 1", c); end
    else begin
      e = expq.pop_front(); exp_ovf |= e.sat;
      ncmp++;
      if (dat(g) !== dat(e)) begin nfail++; $display("FAIL twiddle_model: got %h want %h", dat(g), dat(e)); end
      ncmp++;
      if ({g.y0r[W-1:0], g.y0i[W-1:0], g.y1r[W-1:0], g.y1i[W-1:0]} !== {16'd1000, -16'sd500, 16'd1000, 16'sd500}) begin
        nfail++; $display("FAIL twiddle_lane0: got %h %h %h %h want 03e8 fe0c 03e8 01f4",
                          g.y0r[W-1:0], g.y0i[W-1:0], g.y1r[W-1:0], g.y1i[W-1:0]);
      end
    end
    idle(2);
  endtask

  task automatic test_saturate();
    logic c, ov, ir;
    beat_t g, e;
    zero_data();
    in_a_re[W-1:0] = 16'd30000; in_b_re[W-1:0] = 16'd10000; in_w_re[W-1:0] = 16'd16384;
    out_ready = 1'b1; in_valid = 1'b0; ovf_clr = 1'b1;
    tick(c, ov, ir, g);
    ovf_clr = 1'b0; exp_ovf = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      in_valid = 1'b1; in_sop = 1'b1; in_scale = pass[0];
      tick(c, ov, ir, g);
      if (pass == 0) begin
        ncmp++;
        if (g.sat !== 1'b0) begin nfail++; $display("FAIL ovf_clear: got %b want 0", g.sat); end
      end
      in_valid = 1'b0; in_sop = 1'b0;
      tick(c, ov, ir, g);
      tick(c, ov, ir, g);
      ncmp++;
      if (c !== 1'b1) begin nfail++; $display("FAIL sat_valid: got %b want 1", c); end
      else begin
        e = expq.pop_front();
        ncmp++;
        if (dat(g) !== dat(e)) begin nfail++; $display("FAIL sat_model: got %h want %h", dat(g), dat(e)); end
        ncmp++;
        if ({g.y0r[W-1:0], g.y1r[W-1:0]} !== ((pass == 0) ? {16'd32767, 16'd20000} : {16'd20000, 16'd10000})) begin
          nfail++; $display("FAIL sat_values pass %0d: got %h %h", pass, g.y0r[W-1:0], g.y1r[W-1:0]);
        end
        ncmp++;
        if (g.sat !== 1'b1) begin nfail++; $display("FAIL ovf_sticky pass %0d: got %b want 1", pass, g.sat); end
      end
    end
    // Clear coinciding with a saturating beat entering the output stage.
    in_scale = 1'b0; ovf_clr = 1'b1;
    tick(c, ov, ir, g);
    ovf_clr = 1'b0; in_valid = 1'b1; in_sop = 1'b1;
    tick(c, ov, ir, g);
    ncmp++;
    if (g.sat !== 1'b0) begin nfail++; $display("FAIL ovf_clr_pulse: got %b want 0", g.sat); end
    in_valid = 1'b0; in_sop = 1'b0; ovf_clr = 1'b1;
    tick(c, ov, ir, g);
    tick(c, ov, ir, g);
    ncmp++;
    if (g.sat !== 1'b1) begin nfail++; $display("FAIL ovf_set_wins: got %b want 1", g.sat); end
    ovf_clr = 1'b0;
    tick(c, ov, ir, g);
    ncmp++;
    if (g.sat !== 1'b0) begin nfail++; $display("FAIL ovf_after_clr: got %b want 0", g.sat); end
    exp_ovf = 1'b0;
    idle(1);
  endtask

  task automatic test_rounding();
    logic c, ov, ir;
    beat_t g, e;
    zero_data();
    in_b_re = {-16'sd1, 16'sd1}; in_w_re = {16'd8192, 16'd8192};
    in_valid = 1'b1; in_sop = 1'b1; in_scale = 1'b0; out_ready = 1'b1;
    tick(c, ov, ir, g);
    in_valid = 1'b0; in_sop = 1'b0;
    tick(c, ov, ir, g);
    tick(c, ov, ir, g);
    ncmp++;
    if (c !== 1'b1) begin nfail++; $display("FAIL round_valid: got %b want 1", c); end
    else begin
      e = expq.pop_front(); exp_ovf |= e.sat;
      ncmp++;
      if ({g.y0r, g.y1r, g.y0i, g.y1i} !== {32'h0000_0001, 32'h0000_ffff, 64'h0}) begin
        nfail++; $display("FAIL round_values: y0r %h y1r %h y0i %h y1i %h want 00000001 0000ffff 0 0", g.y0r, g.y1r, g.y0i, g.y1i);
      end
      ncmp++;
      if (dat(g) !== dat(e)) begin nfail++; $display("FAIL round_model: got %h want %h", dat(g), dat(e)); end
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic c, ov, ir, pov, pordy;
    beat_t g, e, pg;
    int fed, got_n, occ;
    fed = 0; got_n = 0; pov = 1'b0; pordy = 1'b1; pg = '0;
    for (int cyc = 0; cyc < 40 && got_n < 8; cyc++) begin
      rand_data();
      in_valid = (fed < 8); in_sop = (fed == 0); in_scale = 1'($urandom_range(0, 1));
      out_ready = !(cyc >= 3 && cyc <= 5);
      occ = expq.size();
      tick(c, ov, ir, g);
      if (in_valid && ir) fed++;
      if (occ == 2 && !out_ready) begin
        ncmp++;
        if (ir !== 1'b0) begin nfail++; $display("FAIL bp_ready_low cyc %0d: got %b want 0", cyc, ir); end
      end
      if (out_ready) begin
        ncmp++;
        if (ir !== 1'b1) begin nfail++; $display("FAIL bp_ready_high cyc %0d: got %b want 1", cyc, ir); end
      end
      if (pov && !pordy) begin
        ncmp++;
        if (ov !== 1'b1 || dat(g) !== dat(pg)) begin
          nfail++; $display("FAIL bp_hold cyc %0d: got %b %h want 1 %h", cyc, ov, dat(g), dat(pg));
        end
      end
      if (c) begin
        e = expq.pop_front(); exp_ovf |= e.sat; got_n++;
        ncmp++;
        if (dat(g) !== dat(e)) begin nfail++; $display("FAIL bp_beat %0d: got %h want %h", got_n, dat(g), dat(e)); end
      end
      pov = ov; pordy = out_ready; pg = g;
    end
    ncmp++;
    if (got_n != 8) begin nfail++; $display("FAIL bp_count: got %0d beats want 8", got_n); end
    idle(2);
  endtask

  task automatic test_random_stream();
    logic c, ov, ir;
    beat_t g, e;
    for (int cyc = 0; cyc < 304; cyc++) begin
      rand_data();
      in_valid  = (cyc < 300) && ($urandom_range(0, 3) != 0);
      in_sop    = ($urandom_range(0, 4) == 0);
      in_scale  = 1'($urandom_range(0, 1));
      out_ready = (cyc >= 300) || ($urandom_range(0, 2) != 0);
      tick(c, ov, ir, g);
      if (c) begin
        ncmp++;
        if (expq.size() == 0) begin nfail++; $display("FAIL rnd_spurious cyc %0d: got beat want none", cyc); end
        else begin
          e = expq.pop_front(); exp_ovf |= e.sat;
          if (dat(g) !== dat(e)) begin nfail++; $display("FAIL rnd_beat cyc %0d: got %h want %h", cyc, dat(g), dat(e)); end
          ncmp++;
          if (g.sat !== exp_ovf) begin nfail++; $display("FAIL rnd_ovf cyc %0d: got %b want %b", cyc, g.sat, exp_ovf); end
        end
      end
    end
    ncmp++;
    if (expq.size() != 0) begin nfail++; $display("FAIL rnd_lost: %0d beats missing want 0", expq.size()); end
    idle(1);
  endtask

  task automatic test_reset_midstream();
    logic c, ov, ir;
    beat_t g, e;
    zero_data();
    in_a_re[W-1:0] = 16'sd32767; in_b_re[W-1:0] = -16'sd32768; in_w_re[W-1:0] = -16'sd32768;
    in_valid = 1'b1; in_sop = 1'b1; in_scale = 1'b1; out_ready = 1'b1;
    tick(c, ov, ir, g);
    in_sop = 1'b0;
    tick(c, ov, ir, g);
    in_valid = 1'b0;
    #1;
    ncmp++;
    if (ovf !== 1'b1) begin nfail++; $display("FAIL rst_pre_ovf: got %b want 1", ovf); end
    #1 rst_n = 1'b0;
    #1;
    ncmp++;
    if (out_valid !== 1'b0 || ovf !== 1'b0 || out_y0_re !== '0) begin
      nfail++; $display("FAIL rst_async: valid %b ovf %b y0re %h want 0 0 0", out_valid, ovf, out_y0_re);
    end
    expq.delete(); tb_scale = 1'b0; exp_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(c, ov, ir, g);
      ncmp++;
      if (ov !== 1'b0) begin nfail++; $display("FAIL rst_stale %0d: out_valid %b want 0", i, ov); end
    end
    zero_data();
    in_b_re[W-1:0] = 16'd1000; in_w_re[W-1:0] = 16'd16384;
    in_valid = 1'b1; in_sop = 1'b0; in_scale = 1'b1;
    tick(c, ov, ir, g);
    in_valid = 1'b0;
    tick(c, ov, ir, g);
    tick(c, ov, ir, g);
    ncmp++;
    if (c !== 1'b1) begin nfail++; $display("FAIL rst_first_valid: got %b want 1", c); end
    else begin
      e = expq.pop_front();
      ncmp++;
      if (g.y0r[W-1:0] !== 16'd1000 || dat(g) !== dat(e)) begin
        nfail++; $display("FAIL rst_scale0: got %h want %h (lane0 y0r 03e8)", dat(g), dat(e));
      end
    end
    idle(1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 test_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_identity();
    test_twiddle();
    test_saturate();
    test_rounding();
    test_back_to_back();
    test_random_stream();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
